// File: rtl/buffer_window_ctrl.sv
// buffer_window_ctrl
// Sequencer for the 4x16-byte line buffer of the windowing datapath.
// Fills the buffer from memory one 32-bit word at a time. It then presents
// every 4x4-byte window of the current 4-row band to a valid/ready consumer.
// It then shifts the buffer up one row, refills the bottom row and repeats
// until the whole image has been swept.

module buffer_window_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int IMG_ROWS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_valid,
  output logic              buf_ld,
  output logic [1:0]        buf_row,
  output logic [1:0]        buf_col,
  output logic              buf_shift_en,
  output logic [3:0]        buf_table_index,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              win_last,
  output logic              busy,
  output logic              done
);

  // img_row must be able to hold IMG_ROWS itself: that value marks the final band
  localparam int              ROW_W    = $clog2(IMG_ROWS + 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_ROWS);
  localparam logic [3:0]      TI_FIRST = 4'd3;
  localparam logic [3:0]      TI_LAST  = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    FILL_REQ,
    FILL_WAIT,
    WIN,
    SHIFT,
    REFILL_REQ,
    REFILL_WAIT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ROW_W-1:0]  img_row;
  logic [1:0]        brow;
  logic [1:0]        bcol;
  logic [3:0]        ti;
  logic [ADDR_W-1:0] rd_addr;
  logic              band_last;

  // Each image row is four words, so the row index is scaled by 4.
  // The sum wraps modulo 2^ADDR_W.
  assign rd_addr   = base_q + (ADDR_W'(img_row) << 2) + ADDR_W'(bcol);
  assign band_last = (img_row == LAST_ROW);

  // The table index is the window right edge.
  // It keeps its last value while no window is being presented.
  assign buf_table_index = ti;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and all control outputs, decoded from the current state
  always_comb begin
    state_nxt    = state;
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
    buf_ld       = 1'b0;
    buf_row      = 2'd0;
    buf_col      = 2'd0;
    buf_shift_en = 1'b0;
    win_valid    = 1'b0;
    win_last     = 1'b0;
    done         = 1'b0;
    busy         = (state != IDLE);

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FILL_REQ;
        end
      end

      FILL_REQ: begin
        mem_rd_en = 1'b1;
        mem_addr  = rd_addr;
        state_nxt = FILL_WAIT;
      end

      FILL_WAIT: begin
        if (mem_rd_valid) begin
          buf_ld    = 1'b1;
          buf_row   = brow;
          buf_col   = bcol;
          state_nxt = (brow == 2'd3 && bcol == 2'd3) ? WIN : FILL_REQ;
        end
      end

      WIN: begin
        win_valid = 1'b1;
        win_last  = (ti == TI_LAST) && band_last;
        if (win_ready && ti == TI_LAST) begin
          state_nxt = band_last ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        buf_shift_en = 1'b1;
        state_nxt    = REFILL_REQ;
      end

      REFILL_REQ: begin
        mem_rd_en = 1'b1;
        mem_addr  = rd_addr;
        state_nxt = REFILL_WAIT;
      end

      REFILL_WAIT: begin
        if (mem_rd_valid) begin
          buf_ld    = 1'b1;
          buf_row   = brow;
          buf_col   = bcol;
          state_nxt = (bcol == 2'd3) ? WIN : REFILL_REQ;
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Base latch, fetch position counters and window index, advanced by state
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      img_row <= '0;
      brow    <= 2'd0;
      bcol    <= 2'd0;
      ti      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            img_row <= '0;
            brow    <= 2'd0;
            bcol    <= 2'd0;
          end
        end

        FILL_WAIT: begin
          if (mem_rd_valid) begin
            bcol <= bcol + 2'd1;
            if (bcol == 2'd3) begin
              brow    <= brow + 2'd1;
              img_row <= img_row + ROW_W'(1);
            end
            if (brow == 2'd3 && bcol == 2'd3) begin
              ti <= TI_FIRST;
            end
          end
        end

        REFILL_WAIT: begin
          if (mem_rd_valid) begin
            bcol <= bcol + 2'd1;
            if (bcol == 2'd3) begin
              // brow wraps 3->0 here; SHIFT forces it back to 3 before the next refill
              brow    <= brow + 2'd1;
              img_row <= img_row + ROW_W'(1);
              ti      <= TI_FIRST;
            end
          end
        end

        WIN: begin
          if (win_ready && ti != TI_LAST) begin
            ti <= ti + 4'd1;
          end
        end

        SHIFT: begin
          brow <= 2'd3;
          bcol <= 2'd0;
        end

        default: begin
        end
      endcase
    end
  end

endmodule
